// File: rtl/wb_intc_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_intc_if
// Description : Wishbone slave bus bundle for the interrupt controller.
//               Signal names keep the Wishbone _i/_o suffixes as seen from
//               the slave side.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_intc_if;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [29:0] adr_i;
    logic [3:0]  sel_i;
    logic [31:0] dat_i;
    logic        ack_o;
    logic [31:0] dat_o;

    modport master (
        output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
        input  ack_o, dat_o
    );

    modport slave (
        input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
        output ack_o, dat_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_intc.sv
`default_nettype none
// ============================================================================
// Module      : wb_intc
// Description : Wishbone-slave interrupt controller. Synchronises and
//               edge-detects IRQS sources into a PENDING register, masks
//               them with ENABLE and GIE, and presents a fixed-priority
//               request/vector to the CPU interface until it acknowledges.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_intc #(
    parameter int IRQS     = 8,
    parameter int VEC_BASE = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    wb_intc_if.slave        wb,
    input  logic [IRQS-1:0] irq_src,
    output logic            irq_req,
    output logic [7:0]      irq_vec,
    input  logic            irq_ack
);

    localparam logic [1:0] c_ADR_PENDING = 2'd0;
    localparam logic [1:0] c_ADR_ENABLE  = 2'd1;
    localparam logic [1:0] c_ADR_CTRL    = 2'd2;
    localparam logic [1:0] c_ADR_STATUS  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [IRQS-1:0] r_sync1;
    logic [IRQS-1:0] r_sync2;
    logic [IRQS-1:0] r_sync3;
    logic [IRQS-1:0] w_edge;

    logic            r_ack;
    logic [31:0]     r_dat;
    logic [IRQS-1:0] r_pend;
    logic [IRQS-1:0] r_enable;
    logic            r_gie;
    logic [4:0]      r_idx;
    logic [7:0]      r_vec;

    state_t          r_state;
    state_t          w_state_next;
    logic            w_load;
    logic            w_ack_fire;

    logic            w_access;
    logic            w_wr;
    logic            w_wr_pend;
    logic            w_wr_enable;
    logic            w_wr_ctrl;
    logic [31:0]     w_bmask;
    logic [31:0]     w_wdata;
    logic [IRQS-1:0] w_lane_mask;
    logic [IRQS-1:0] w_w1c;
    logic [IRQS-1:0] w_ack_clr;
    logic [31:0]     w_rdata;

    logic [IRQS-1:0] w_elig;
    logic [4:0]      w_win_idx;
    logic [7:0]      w_win_vec;
    logic            w_unused;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    // A strobe is only taken while no ack is outstanding, which yields the
    // single registered ack and the every-other-cycle back-to-back rate.
    assign w_access    = wb.cyc_i & wb.stb_i & ~r_ack;
    assign w_wr        = w_access & wb.we_i;
    assign w_wr_pend   = w_wr & (wb.adr_i[1:0] == c_ADR_PENDING);
    assign w_wr_enable = w_wr & (wb.adr_i[1:0] == c_ADR_ENABLE);
    assign w_wr_ctrl   = w_wr & (wb.adr_i[1:0] == c_ADR_CTRL);

    assign w_bmask     = {{8{wb.sel_i[3]}}, {8{wb.sel_i[2]}},
                          {8{wb.sel_i[1]}}, {8{wb.sel_i[0]}}};
    assign w_wdata     = wb.dat_i & w_bmask;
    assign w_lane_mask = w_bmask[IRQS-1:0];
    assign w_w1c       = w_wr_pend ? w_wdata[IRQS-1:0] : '0;

    // Ack is qualified by cyc so an aborted cycle never sees a stray ack.
    assign wb.ack_o    = r_ack & wb.cyc_i;
    assign wb.dat_o    = r_dat;

    assign irq_req     = (r_state == S_REQ);
    assign irq_vec     = r_vec;

    // Upper address and data bits beyond IRQS carry no state.
    assign w_unused    = ^{wb.adr_i[29:2], w_wdata, w_bmask};

    // ------------------------------------------------------------------
    // Source conditioning
    // ------------------------------------------------------------------
    assign w_edge = r_sync2 & ~r_sync3;

    // Two-flop synchroniser plus a history flop for rising-edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= irq_src;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // ------------------------------------------------------------------
    // Priority selection
    // ------------------------------------------------------------------
    assign w_elig = r_pend & r_enable & {IRQS{r_gie}};

    // Lowest eligible index wins; scanning downward leaves it last written.
    always_comb begin
        w_win_idx = 5'd0;
        for (int i = IRQS - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_win_idx = 5'(i);
            end
        end
    end

    assign w_win_vec = 8'(VEC_BASE) + {3'b000, w_win_idx};

    // One-hot clear of the latched source when the CPU acknowledges.
    always_comb begin
        w_ack_clr = '0;
        for (int i = 0; i < IRQS; i++) begin
            w_ack_clr[i] = w_ack_fire & (r_idx == 5'(i));
        end
    end

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state; REQ ignores mask changes because an IACK may be in flight.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_ack_fire   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|w_elig) begin
                    w_load       = 1'b1;
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (irq_ack) begin
                    w_ack_fire   = 1'b1;
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Latch the winning source and vector as the request is raised.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_idx <= 5'd0;
            r_vec <= 8'd0;
        end else if (w_load) begin
            r_idx <= w_win_idx;
            r_vec <= w_win_vec;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // PENDING: a new edge overrides any clear from software or acknowledge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~(w_w1c | w_ack_clr)) | w_edge;
        end
    end

    // ENABLE and GIE with per-byte-lane write masking.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_enable <= '0;
            r_gie    <= 1'b0;
        end else begin
            if (w_wr_enable) begin
                r_enable <= (r_enable & ~w_lane_mask) |
                            (w_wdata[IRQS-1:0] & w_lane_mask);
            end
            if (w_wr_ctrl && wb.sel_i[0]) begin
                r_gie <= wb.dat_i[0];
            end
        end
    end

    // Read-data mux; STATUS has no write path.
    always_comb begin
        w_rdata = 32'd0;
        case (wb.adr_i[1:0])
            c_ADR_PENDING: w_rdata = 32'(r_pend);
            c_ADR_ENABLE:  w_rdata = 32'(r_enable);
            c_ADR_CTRL:    w_rdata = {31'd0, r_gie};
            c_ADR_STATUS:  w_rdata = {15'd0, (r_state == S_REQ), r_vec,
                                      3'd0, r_idx};
            default:       w_rdata = 32'd0;
        endcase
    end

    // Registered ack and read data, valid together one cycle after strobe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ack <= 1'b0;
            r_dat <= 32'd0;
        end else begin
            r_ack <= w_access;
            r_dat <= w_access ? w_rdata : 32'd0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_intc.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_intc
// Description : Directed self-checking bench for wb_intc (IRQS=8,
//               VEC_BASE=64). Expected values are queued as stimulus is
//               issued and popped when the DUT responds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_intc;

    logic       clk;
    logic       rst;
    logic [7:0] irq_src;
    logic       irq_req;
    logic [7:0] irq_vec;
    logic       irq_ack;

    int compared;
    int mismatched;

    logic [31:0] exp_q[$];

    wb_intc_if bus ();

    wb_intc #(.IRQS(8), .VEC_BASE(64)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .wb      (bus.slave),
        .irq_src (irq_src),
        .irq_req (irq_req),
        .irq_vec (irq_vec),
        .irq_ack (irq_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One Wishbone access; the ack must arrive exactly one clock after strobe.
    task automatic wb_xfer(input string tag, input logic we,
                           input logic [1:0] adr, input logic [3:0] sel,
                           input logic [31:0] wdat, output logic [31:0] rdat);
        int lat;
        lat = 0;
        rdat = 32'd0;
        bus.cyc_i = 1'b1;
        bus.stb_i = 1'b1;
        bus.we_i  = we;
        bus.adr_i = {28'd0, adr};
        bus.sel_i = sel;
        bus.dat_i = wdat;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.ack_o) begin
                rdat = bus.dat_o;
                break;
            end
        end
        bus.cyc_i = 1'b0;
        bus.stb_i = 1'b0;
        bus.we_i  = 1'b0;
        check({tag, " ack latency"}, 32'(lat), 32'd1);
        tick(1);
    endtask

    task automatic wr(input string tag, input logic [1:0] adr,
                      input logic [3:0] sel, input logic [31:0] dat);
        logic [31:0] d;
        wb_xfer(tag, 1'b1, adr, sel, dat, d);
    endtask

    task automatic rd(input string tag, input logic [1:0] adr,
                      input logic [31:0] exp);
        logic [31:0] d;
        exp_q.push_back(exp);
        wb_xfer(tag, 1'b0, adr, 4'hF, 32'd0, d);
        check(tag, d, exp_q.pop_front());
    endtask

    task automatic pulse_src(input logic [7:0] mask);
        irq_src = irq_src | mask;
        tick(1);
        irq_src = irq_src & ~mask;
    endtask

    // Bounded wait for a request, then compare its vector.
    task automatic wait_irq(input string tag, input logic [7:0] vec);
        exp_q.push_back({24'd0, vec});
        for (int i = 0; i < 10; i++) begin
            if (irq_req) break;
            tick(1);
        end
        check({tag, " irq_req"}, {31'd0, irq_req}, 32'd1);
        check({tag, " irq_vec"}, {24'd0, irq_vec}, exp_q.pop_front());
    endtask

    task automatic ack_pulse(input string tag);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        check({tag, " req drop"}, {31'd0, irq_req}, 32'd0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        irq_src    = 8'd0;
        irq_ack    = 1'b0;
        bus.cyc_i  = 1'b0;
        bus.stb_i  = 1'b0;
        bus.we_i   = 1'b0;
        bus.adr_i  = 30'd0;
        bus.sel_i  = 4'd0;
        bus.dat_i  = 32'd0;

        // Reset state
        tick(3);
        check("reset irq_req", {31'd0, irq_req}, 32'd0);
        check("reset irq_vec", {24'd0, irq_vec}, 32'd0);
        check("reset ack_o",   {31'd0, bus.ack_o}, 32'd0);
        check("reset dat_o",   bus.dat_o, 32'd0);
        rst = 1'b0;
        tick(2);
        rd("reset PENDING", 2'd0, 32'd0);
        rd("reset ENABLE",  2'd1, 32'd0);
        rd("reset CTRL",    2'd2, 32'd0);

        // Basic request on source 2
        wr("basic wr ENABLE", 2'd1, 4'hF, 32'h0000_0004);
        wr("basic wr CTRL",   2'd2, 4'hF, 32'h0000_0001);
        pulse_src(8'h04);
        wait_irq("basic", 8'd66);
        rd("basic PENDING", 2'd0, 32'h0000_0004);
        rd("basic STATUS",  2'd3, 32'h0001_4202);
        ack_pulse("basic");
        tick(1);
        check("basic gap 1", {31'd0, irq_req}, 32'd0);
        tick(1);
        check("basic gap 2", {31'd0, irq_req}, 32'd0);
        rd("basic PENDING after ack", 2'd0, 32'd0);

        // Priority: sources 5 and 3 together
        wr("prio wr ENABLE", 2'd1, 4'hF, 32'h0000_00FF);
        pulse_src(8'h28);
        wait_irq("prio first", 8'd67);
        ack_pulse("prio first");
        wait_irq("prio second", 8'd69);
        ack_pulse("prio second");
        tick(2);
        rd("prio PENDING", 2'd0, 32'd0);

        // Masking by GIE
        wr("mask GIE off", 2'd2, 4'hF, 32'd0);
        pulse_src(8'h02);
        tick(6);
        check("mask gie idle", {31'd0, irq_req}, 32'd0);
        rd("mask PENDING", 2'd0, 32'h0000_0002);
        wr("mask GIE on", 2'd2, 4'hF, 32'd1);
        wait_irq("mask gie", 8'd65);
        ack_pulse("mask gie");
        tick(2);
        // Masking by ENABLE
        wr("mask wr ENABLE", 2'd1, 4'hF, 32'h0000_00FD);
        pulse_src(8'h02);
        tick(6);
        check("mask enable idle", {31'd0, irq_req}, 32'd0);
        rd("mask PENDING 2", 2'd0, 32'h0000_0002);
        wr("mask w1c", 2'd0, 4'hF, 32'h0000_0002);
        rd("mask PENDING cleared", 2'd0, 32'd0);

        // Register access: byte lanes, width, read-only STATUS
        wr("reg clr ENABLE", 2'd1, 4'hF, 32'd0);
        wr("reg lane1", 2'd1, 4'b0010, 32'hFFFF_FFFF);
        rd("reg ENABLE lane1", 2'd1, 32'd0);
        wr("reg lane0", 2'd1, 4'b0001, 32'hFFFF_FFFF);
        rd("reg ENABLE lane0", 2'd1, 32'h0000_00FF);
        wr("reg wr STATUS", 2'd3, 4'hF, 32'hFFFF_FFFF);
        rd("reg STATUS", 2'd3, 32'h0000_4101);
        rd("reg CTRL", 2'd2, 32'h0000_0001);

        // Collision: ack and new edge on source 4 in the same cycle
        pulse_src(8'h10);
        wait_irq("coll first", 8'd68);
        irq_src = 8'h10;        // sync1 at next edge, edge detected two later
        tick(2);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        irq_src = 8'h00;
        check("coll req drop", {31'd0, irq_req}, 32'd0);
        wait_irq("coll second", 8'd68);
        rd("coll PENDING", 2'd0, 32'h0000_0010);
        ack_pulse("coll second");
        tick(2);
        rd("coll PENDING after", 2'd0, 32'd0);

        // Software W1C of the latched source while requesting
        pulse_src(8'h40);
        wait_irq("w1c", 8'd70);
        wr("w1c clear", 2'd0, 4'hF, 32'h0000_0040);
        rd("w1c PENDING", 2'd0, 32'd0);
        check("w1c req held", {31'd0, irq_req}, 32'd1);
        check("w1c vec held", {24'd0, irq_vec}, 32'd70);
        ack_pulse("w1c");
        tick(4);
        check("w1c no retrigger", {31'd0, irq_req}, 32'd0);

        // irq_ack outside REQ is ignored
        wr("idle ack GIE off", 2'd2, 4'hF, 32'd0);
        pulse_src(8'h01);
        tick(4);
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
        rd("idle ack PENDING", 2'd0, 32'h0000_0001);
        wr("idle ack GIE on", 2'd2, 4'hF, 32'd1);
        wait_irq("idle ack", 8'd64);

        // Asynchronous reset while the request is up
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async rst irq_req", {31'd0, irq_req}, 32'd0);
        check("async rst irq_vec", {24'd0, irq_vec}, 32'd0);
        tick(2);
        rst = 1'b0;
        tick(1);
        rd("post rst PENDING", 2'd0, 32'd0);
        rd("post rst ENABLE",  2'd1, 32'd0);
        rd("post rst CTRL",    2'd2, 32'd0);
        pulse_src(8'h04);
        tick(8);
        check("post rst no req", {31'd0, irq_req}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

    // Absolute time limit so a stuck run still ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/wb_intc.md
Name: wb_intc

Overview:
- Wishbone-slave interrupt controller that generates the CPU interface's interrupt request and vector (irq_req / irq_vec / irq_ack).
- Collects up to IRQS peripheral sources (timer, UART, SPI, Ethernet eth_int), edge-detects them and latches them as pending.
- Applies per-source and global enables, picks a fixed-priority winner and holds a request until the CPU's interrupt acknowledge completes.
- Sits as one slave on the peripheral arbiter; software programs it through four word registers.

Parameters:
- IRQS, 8, number of interrupt sources (1..32).
- VEC_BASE, 64, vector number presented for source 0; source n presents VEC_BASE+n. Required: VEC_BASE+IRQS-1 <= 255.

Ports:
- clk_i  in  1  system clock (sys_clk).
- rst_i  in  1  reset; asynchronous, active-high.
- cyc_i  in  1  Wishbone cycle.
- stb_i  in  1  Wishbone strobe, already decoded for this slave.
- we_i  in  1  write enable.
- adr_i  in  30  word address; only adr_i[1:0] used.
- sel_i  in  4  byte lane enables.
- dat_i  in  32  write data.
- ack_o  out  1  Wishbone acknowledge.
- dat_o  out  32  read data.
- irq_src  in  IRQS  raw source lines, asynchronous, active-high.
- irq_req  out  1  interrupt request to the CPU interface.
- irq_vec  out  8  vector for the current request.
- irq_ack  in  1  one-cycle pulse from the CPU interface when the IACK cycle completes.

Behaviour:
- Reset values: ack_o=0, dat_o=0, irq_req=0, irq_vec=0, PENDING=0, ENABLE=0, GIE=0, FSM=IDLE, synchronizers=0.
- Source input: each irq_src bit passes through a 2-flop synchronizer followed by a rising-edge detector. A rising edge sets PENDING[n] on the cycle it is detected (3rd clk after the input rises). A held-high level does not re-trigger.
- Register map (adr_i[1:0]):
  - 0 PENDING: read; write-1-to-clear per bit.
  - 1 ENABLE: read/write.
  - 2 CTRL: bit0 GIE, read/write.
  - 3 STATUS: read-only; bit16=busy (FSM in REQ), bits[15:8]=latched vector, bits[4:0]=latched source index.
- Register access rules:
  - Bits at or above IRQS read 0 and ignore writes.
  - Writes honour sel_i per byte lane. Writes to STATUS are ignored.
- Wishbone timing: single registered ack. ack_o=1 exactly one cycle after stb_i&cyc_i is seen with ack_o low, and dat_o is valid in that same cycle. Back-to-back strobes receive an ack every other cycle. ack_o never asserts without cyc_i.
- Eligible set: PENDING & ENABLE, gated by GIE. Winner is the lowest index in the eligible set (index 0 has highest priority).
- FSM:
  - IDLE: if the eligible set is nonzero, latch winner index and irq_vec=VEC_BASE+index, then go to REQ. irq_req=1 from the next cycle.
  - REQ: irq_req=1 and irq_vec stable. Holds regardless of later changes to PENDING, ENABLE or GIE, because the CPU may already be in an IACK cycle. On irq_ack: clear PENDING[latched index], drop irq_req, go to HOLD.
  - HOLD: one cycle with irq_req=0, then IDLE. This guarantees a deasserted gap so the CPU interface sees a fresh request.
- Simultaneous events:
  - A new edge on source n in the same cycle as a W1C of bit n, or as irq_ack clearing bit n: the set wins and PENDING[n] stays 1.
  - irq_ack outside REQ is ignored.
  - Software W1C of the latched source during REQ: PENDING clears, but the request still completes with the latched vector. Software handles it as spurious.
- Reset mid-operation: rst_i asserted at any time forces all reset values immediately (asynchronously), including dropping irq_req mid-request.

Test Plan:
- Basic request:
  - Stimulus: write ENABLE=0x04, CTRL=1; pulse irq_src[2].
  - Required: PENDING reads 0x04; irq_req=1 within 5 clks with irq_vec=66; STATUS reads 0x0001_4202.
  - Then pulse irq_ack: irq_req=0 next cycle, PENDING reads 0x00, and irq_req stays 0 for at least 2 cycles.
- Priority:
  - Stimulus: ENABLE=0xFF, GIE=1; pulse sources 5 and 3 in the same cycle.
  - Required: first request has vec 67; after ack and HOLD, second request has vec 69; after second ack, PENDING=0.
- Masking:
  - Stimulus: GIE=0, pulse source 1.
  - Required: PENDING=0x02, irq_req stays 0. Write GIE=1 → irq_req=1 with vec 65. Separately, ENABLE bit 1 clear with GIE=1 → no request.
- Register access:
  - Stimulus: write ENABLE=0xFFFF_FFFF with sel_i=0001 (IRQS=8).
  - Required: ENABLE reads 0x0000_00FF; every access acked exactly 1 cycle after strobe; STATUS write has no effect.
- Collision:
  - Stimulus: irq_ack for source 4 in the same cycle a new edge on source 4 is detected.
  - Required: PENDING[4] stays 1 and a second request with vec 68 follows after HOLD.
- Reset mid-request:
  - Stimulus: assert rst_i while irq_req=1.
  - Required: irq_req=0 and irq_vec=0 asynchronously; PENDING, ENABLE and CTRL read 0 after release; no request until reprogrammed.
